dht_uart_formatter: RTL and testbench
=====================================

Name: dht_uart_formatter

Overview:
- Sits directly upstream of the UART controller's transmit side.
- Takes one DHT11 reading (integer humidity, integer temperature, checksum status) and turns it into a fixed ASCII line.
- Feeds that line byte-by-byte into the UART TX path using the tdata/send/trdy handshake.
- Lets the sensor reader push a result with a single pulse, without knowing about the UART.

Parameters:
- BUSY_WAIT, 16: maximum mclk cycles to wait for trdy to fall after a send pulse before declaring tx_timeout.

Ports:
- mclk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- dv  input  1  one-cycle pulse; hum_int/temp_int/chk_err valid this cycle.
- hum_int  input  8  humidity integer, 0..255.
- temp_int  input  8  temperature integer, 0..255.
- chk_err  input  1  DHT11 checksum failed for this reading.
- trdy  input  1  UART TX ready/done; high = transmitter idle.
- tdata  output  8  byte to transmit.
- send  output  1  one-cycle transmit request.
- busy  output  1  high whenever state != IDLE.
- dropped  output  1  one-cycle pulse: dv arrived while busy.
- tx_timeout  output  1  one-cycle pulse: trdy did not fall within BUSY_WAIT.
- msg_done  output  1  one-cycle pulse after the last byte is acknowledged.

Behaviour:
- Reset (async, active-high): state=IDLE; tdata=8'h00; send, busy, dropped, tx_timeout, msg_done all 0; byte index=0; captured values=0.
- Normal message, 15 bytes, leading zeros kept: "H:" h2 h1 h0 "% T:" t2 t1 t0 "C" CR LF.
- Error message (chk_err=1 at capture), 5 bytes: "ERR" CR LF.
- FSM states: IDLE, CONV, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - dv=1: capture hum_int, temp_int, chk_err; index=0.
  - chk_err=1 -> SEND with the error message selected.
  - chk_err=0 -> CONV; start both bin-to-BCD converters.
- CONV:
  - Two converters run in parallel, each exactly 8 cycles (double-dabble, one bit per cycle).
  - When both report done -> SEND.
  - dv-to-first-send latency: 10 cycles (normal), 1 cycle (error), provided trdy=1.
- SEND:
  - Wait while trdy=0.
  - When trdy=1: drive tdata=char[index] and send=1 for exactly one cycle -> WAIT_BUSY; clear the wait counter.
  - tdata stays stable from the send cycle until the next byte's send cycle.
- WAIT_BUSY:
  - trdy=0 -> WAIT_DONE.
  - Otherwise increment the counter; when it reaches BUSY_WAIT, pulse tx_timeout and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for trdy=1.
  - If index == len-1: pulse msg_done, go to IDLE, index=0.
  - Otherwise index+1 -> SEND.
  - SEND then requires trdy=1 again, so back-to-back bytes never overlap.
- Digit encoding: ASCII = 8'h30 + BCD digit; hundreds digit is 0..2.
- dv while busy=1 (including the same cycle as msg_done) -> dropped=1 for that cycle; the message in progress is unaffected and the new values are not captured.
- dv in IDLE always accepted; dropped=0.
- Reset mid-message: immediate abort, outputs go to reset values, no partial resume. The next dv starts a fresh message from 'H'.
- Outputs are registered; no combinational path from trdy to send.

Decomposition:
- Shared package:
  - ASCII constants: CH_H 8'h48, CH_COLON 8'h3A, CH_PCT 8'h25, CH_SP 8'h20, CH_T 8'h54, CH_C 8'h43, CH_E 8'h45, CH_R 8'h52, CH_CR 8'h0D, CH_LF 8'h0A, CH_0 8'h30.
  - MSG_LEN_OK=15, MSG_LEN_ERR=5.
  - State encoding.
- Sub-module bin2bcd8:
  - Sequential double-dabble with start/done, 8-bit in, 12-bit BCD out.
  - Instantiated twice.

Test Plan:
- hum_int=45, temp_int=23, chk_err=0, UART model acks each byte -> tdata sequence 48 3A 30 34 35 25 20 54 3A 30 32 33 43 0D 0A, 15 send pulses, one msg_done, busy falls after it.
- hum_int=255, temp_int=0 -> digits "255" (32 35 35) and "000" (30 30 30); msg_done once.
- chk_err=1 (hum=99, temp=99) -> 45 52 52 0D 0A; no CONV cycles; first send 1 cycle after dv.
- Second dv 3 cycles after first, and another on the msg_done cycle -> dropped pulses on both; transmitted bytes match only the first reading.
- UART model holds trdy=1 permanently -> each byte gets tx_timeout after 16 cycles; 15 tx_timeout pulses; message completes.
- Assert reset during byte 7 -> send=0, busy=0, tdata=00 at once; next dv with 12/34 yields a full "H:012% T:034C\r\n".

Source files
------------

// File: rtl/dht_uart_formatter_pkg.sv
// Shared constants and types for the DHT11 reading to UART line formatter.
package dht_uart_formatter_pkg;

  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_PCT   = 8'h25;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;

  localparam int unsigned MSG_LEN_OK  = 15;
  localparam int unsigned MSG_LEN_ERR = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  // ASCII character for one BCD digit.
  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return CH_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one bit per cycle.
// A start pulse loads the operand; done rises 8 cycles later and holds
// until the next start.
module bin2bcd8 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        done_o
);

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic        run_q;
  logic        done_q;
  logic [11:0] adj;

  // Add 3 to every BCD digit that is 5 or more before the next shift.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift one binary bit into the BCD field per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= {adj[10:0], bin_q[7]};
      bin_q <= {bin_q[6:0], 1'b0};
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/dht_uart_formatter.sv
// Turns one DHT11 reading into a fixed ASCII line and streams it byte by
// byte into the UART TX path over the tdata/send/trdy handshake.
module dht_uart_formatter
  import dht_uart_formatter_pkg::*;
#(
  parameter int unsigned BUSY_WAIT = 16
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       dv,
  input  logic [7:0] hum_int,
  input  logic [7:0] temp_int,
  input  logic       chk_err,
  input  logic       trdy,
  output logic [7:0] tdata,
  output logic       send,
  output logic       busy,
  output logic       dropped,
  output logic       tx_timeout,
  output logic       msg_done
);

  localparam int unsigned    CW       = $clog2(BUSY_WAIT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BUSY_WAIT - 1);
  localparam logic [3:0]     LAST_OK  = 4'(MSG_LEN_OK - 1);
  localparam logic [3:0]     LAST_ERR = 4'(MSG_LEN_ERR - 1);

  state_t        state_q;
  logic [3:0]    idx_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    tdata_q;
  logic          send_q;
  logic          busy_q;
  logic          dropped_q;
  logic          timeout_q;
  logic          done_q;

  logic          conv_start;
  logic [11:0]   hum_bcd;
  logic [11:0]   temp_bcd;
  logic          hum_done;
  logic          temp_done;
  logic [7:0]    char_d;
  logic [3:0]    last_idx;

  // The converters register the raw reading themselves on the accept cycle,
  // so they double as the capture registers for humidity and temperature.
  assign conv_start = (state_q == ST_IDLE) && dv && !chk_err;

  bin2bcd8 u_hum_bcd (
    .clk_i   (mclk),
    .rst_i   (reset),
    .start_i (conv_start),
    .bin_i   (hum_int),
    .bcd_o   (hum_bcd),
    .done_o  (hum_done)
  );

  bin2bcd8 u_temp_bcd (
    .clk_i   (mclk),
    .rst_i   (reset),
    .start_i (conv_start),
    .bin_i   (temp_int),
    .bcd_o   (temp_bcd),
    .done_o  (temp_done)
  );

  assign last_idx = err_q ? LAST_ERR : LAST_OK;

  // Character at the current message index.
  always_comb begin
    char_d = '0;
    if (err_q) begin
      case (idx_q)
        4'd0:       char_d = CH_E;
        4'd1, 4'd2: char_d = CH_R;
        4'd3:       char_d = CH_CR;
        4'd4:       char_d = CH_LF;
        default:    char_d = '0;
      endcase
    end else begin
      case (idx_q)
        4'd0:    char_d = CH_H;
        4'd1:    char_d = CH_COLON;
        4'd2:    char_d = ascii_digit(hum_bcd[11:8]);
        4'd3:    char_d = ascii_digit(hum_bcd[7:4]);
        4'd4:    char_d = ascii_digit(hum_bcd[3:0]);
        4'd5:    char_d = CH_PCT;
        4'd6:    char_d = CH_SP;
        4'd7:    char_d = CH_T;
        4'd8:    char_d = CH_COLON;
        4'd9:    char_d = ascii_digit(temp_bcd[11:8]);
        4'd10:   char_d = ascii_digit(temp_bcd[7:4]);
        4'd11:   char_d = ascii_digit(temp_bcd[3:0]);
        4'd12:   char_d = CH_C;
        4'd13:   char_d = CH_CR;
        4'd14:   char_d = CH_LF;
        default: char_d = '0;
      endcase
    end
  end

  // Message sequencer with registered handshake and status pulses.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      send_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= dv && (state_q != ST_IDLE);

      case (state_q)
        ST_IDLE: begin
          if (dv) begin
            err_q   <= chk_err;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= chk_err ? ST_SEND : ST_CONV;
          end
        end

        ST_CONV: begin
          if (hum_done && temp_done) begin
            state_q <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (trdy) begin
            tdata_q <= char_d;
            send_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_WAIT_BUSY;
          end
        end

        ST_WAIT_BUSY: begin
          if (!trdy) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= ST_WAIT_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (trdy) begin
            if (idx_q == last_idx) begin
              done_q  <= 1'b1;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= ST_SEND;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tdata      = tdata_q;
  assign send       = send_q;
  assign busy       = busy_q;
  assign dropped    = dropped_q;
  assign tx_timeout = timeout_q;
  assign msg_done   = done_q;

endmodule

// File: tb/tb_dht_uart_formatter.sv
// Self-checking bench for dht_uart_formatter: table of readings with expected
// ASCII lines fed through a byte scoreboard, plus drop/timeout/reset sequences.
module tb_dht_uart_formatter;

  logic       mclk = 1'b0;
  logic       reset;
  logic       dv;
  logic [7:0] hum_int;
  logic [7:0] temp_int;
  logic       chk_err;
  logic       trdy;
  logic [7:0] tdata;
  logic       send;
  logic       busy;
  logic       dropped;
  logic       tx_timeout;
  logic       msg_done;

  always #5 mclk = ~mclk;

  dht_uart_formatter #(.BUSY_WAIT(16)) dut (
    .mclk       (mclk),
    .reset      (reset),
    .dv         (dv),
    .hum_int    (hum_int),
    .temp_int   (temp_int),
    .chk_err    (chk_err),
    .trdy       (trdy),
    .tdata      (tdata),
    .send       (send),
    .busy       (busy),
    .dropped    (dropped),
    .tx_timeout (tx_timeout),
    .msg_done   (msg_done)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] exp_q[$];
  int n_send = 0;
  int n_done = 0;
  int n_to   = 0;
  int n_drop = 0;
  int cyc    = 0;
  int dv_cyc = 0;
  int first_send_cyc = 0;
  int last_send_cyc  = 0;
  bit want_first = 1'b0;
  bit stuck = 1'b0;
  int hold = 0;

  typedef struct {
    logic [7:0]   hum;
    logic [7:0]   temp;
    logic         err;
    int           len;
    logic [119:0] exp;
  } vec_t;

  vec_t vecs[8];

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // UART transmitter model: trdy drops the cycle after a send and returns
  // three cycles later; in stuck mode trdy never leaves 1.
  always @(posedge mclk or posedge reset) begin
    if (reset) begin
      trdy <= 1'b1;
      hold <= 0;
    end else if (stuck) begin
      trdy <= 1'b1;
    end else if (send && trdy) begin
      trdy <= 1'b0;
      hold <= 2;
    end else if (!trdy) begin
      if (hold == 0) trdy <= 1'b1;
      else hold <= hold - 1;
    end
  end

  // Output monitor and byte scoreboard.
  always @(negedge mclk) begin
    if (!reset) begin
      if (send) begin
        n_send++;
        last_send_cyc = cyc;
        if (want_first) begin
          first_send_cyc = cyc;
          want_first = 1'b0;
        end
        if (exp_q.size() == 0) begin
          fail("unexpected_send");
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("tdata", {24'h0, tdata}, {24'h0, e});
        end
      end
      if (msg_done) n_done++;
      if (dropped) n_drop++;
      if (tx_timeout) begin
        n_to++;
        if (stuck) check("timeout_gap", cyc - last_send_cyc, 16);
      end
    end
  end

  function automatic logic [119:0] to_msg(input int h, input int t);
    return {8'h48, 8'h3A, 8'(8'h30 + h / 100), 8'(8'h30 + (h / 10) % 10), 8'(8'h30 + h % 10),
            8'h25, 8'h20, 8'h54, 8'h3A,
            8'(8'h30 + t / 100), 8'(8'h30 + (t / 10) % 10), 8'(8'h30 + t % 10),
            8'h43, 8'h0D, 8'h0A};
  endfunction

  task automatic push_msg(input logic [119:0] m, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(m[119 - 8*i -: 8]);
  endtask

  task automatic drive_dv(input logic [7:0] h, input logic [7:0] t, input logic e);
    @(negedge mclk);
    hum_int = h; temp_int = t; chk_err = e; dv = 1'b1;
    want_first = 1'b1;
    @(negedge mclk);
    dv = 1'b0;
    dv_cyc = cyc;
  endtask

  task automatic pulse_dv(input logic [7:0] h, input logic [7:0] t);
    hum_int = h; temp_int = t; chk_err = 1'b0; dv = 1'b1;
    @(negedge mclk);
    dv = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge mclk);
      if (!busy) break;
    end
    if (k == budget) fail(name);
    @(negedge mclk);
  endtask

  initial begin
    int s0, d0, r0, t0, k;

    vecs[0] = '{8'd45,  8'd23,  1'b0, 15, 120'h483A303435_2520543A30_3233430D0A};
    vecs[1] = '{8'd255, 8'd0,   1'b0, 15, 120'h483A323535_2520543A30_3030430D0A};
    vecs[2] = '{8'd99,  8'd99,  1'b1, 5,  120'h4552520D0A_0000000000_0000000000};
    vecs[3] = '{8'd0,   8'd255, 1'b0, 15, 120'h483A303030_2520543A32_3535430D0A};
    vecs[4] = '{8'd100, 8'd9,   1'b0, 15, 120'h483A313030_2520543A30_3039430D0A};
    for (int i = 5; i < 8; i++) begin
      vecs[i].hum  = 8'($urandom_range(0, 255));
      vecs[i].temp = 8'($urandom_range(0, 255));
      vecs[i].err  = 1'b0;
      vecs[i].len  = 15;
      vecs[i].exp  = to_msg(int'(vecs[i].hum), int'(vecs[i].temp));
    end

    reset = 1'b1; dv = 1'b0; hum_int = '0; temp_int = '0; chk_err = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_tdata",   {24'h0, tdata}, 0);
    check("rst_send",    {31'h0, send}, 0);
    check("rst_busy",    {31'h0, busy}, 0);
    check("rst_dropped", {31'h0, dropped}, 0);
    check("rst_timeout", {31'h0, tx_timeout}, 0);
    check("rst_done",    {31'h0, msg_done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge mclk);

    // Table of readings, UART acking every byte.
    for (int i = 0; i < 8; i++) begin
      s0 = n_send; d0 = n_done; r0 = n_drop; t0 = n_to;
      push_msg(vecs[i].exp, vecs[i].len);
      drive_dv(vecs[i].hum, vecs[i].temp, vecs[i].err);
      wait_idle("vec_idle_timeout", 1000);
      check("latency",   first_send_cyc - dv_cyc, vecs[i].err ? 1 : 10);
      check("send_cnt",  n_send - s0, vecs[i].len);
      check("done_cnt",  n_done - d0, 1);
      check("queue_left", exp_q.size(), 0);
      check("drop_cnt",  n_drop - r0, 0);
      check("to_cnt",    n_to - t0, 0);
      check("busy_end",  {31'h0, busy}, 0);
    end

    // dv while busy: 3 cycles after accept and on the msg_done cycle.
    s0 = n_send; d0 = n_done; r0 = n_drop;
    push_msg(vecs[0].exp, 15);
    drive_dv(8'd45, 8'd23, 1'b0);
    @(negedge mclk);
    pulse_dv(8'd1, 8'd2);
    for (k = 0; k < 1000 && n_send < s0 + 15; k++) @(negedge mclk);
    if (k == 1000) fail("drop_wait_last_send");
    for (k = 0; k < 100 && trdy; k++) @(negedge mclk);
    if (k == 100) fail("drop_wait_trdy_low");
    for (k = 0; k < 100 && !trdy; k++) @(negedge mclk);
    if (k == 100) fail("drop_wait_trdy_high");
    check("busy_before_done", {31'h0, busy}, 1);
    pulse_dv(8'd7, 8'd8);
    check("done_same_cycle",    {31'h0, msg_done}, 1);
    check("dropped_same_cycle", {31'h0, dropped}, 1);
    repeat (30) @(negedge mclk);
    check("drop_total", n_drop - r0, 2);
    check("drop_done",  n_done - d0, 1);
    check("drop_sends", n_send - s0, 15);
    check("drop_queue", exp_q.size(), 0);

    // trdy stuck high: every byte times out, message still completes.
    stuck = 1'b1;
    s0 = n_send; d0 = n_done; t0 = n_to;
    push_msg(vecs[0].exp, 15);
    drive_dv(8'd45, 8'd23, 1'b0);
    wait_idle("stuck_idle_timeout", 2000);
    check("stuck_to_cnt", n_to - t0, 15);
    check("stuck_done",   n_done - d0, 1);
    check("stuck_sends",  n_send - s0, 15);
    check("stuck_queue",  exp_q.size(), 0);
    stuck = 1'b0;
    repeat (2) @(negedge mclk);

    // Reset during byte 7, then a fresh message.
    s0 = n_send;
    push_msg(vecs[0].exp, 15);
    drive_dv(8'd45, 8'd23, 1'b0);
    for (k = 0; k < 1000 && n_send < s0 + 7; k++) @(negedge mclk);
    if (k == 1000) fail("reset_wait_byte7");
    @(negedge mclk);
    reset = 1'b1;
    #1;
    check("midrst_send",  {31'h0, send}, 0);
    check("midrst_busy",  {31'h0, busy}, 0);
    check("midrst_tdata", {24'h0, tdata}, 0);
    exp_q.delete();
    @(negedge mclk);
    reset = 1'b0;
    repeat (2) @(negedge mclk);
    s0 = n_send; d0 = n_done;
    push_msg(120'h483A303132_2520543A30_3334430D0A, 15);
    drive_dv(8'd12, 8'd34, 1'b0);
    wait_idle("post_reset_idle_timeout", 1000);
    check("post_rst_latency", first_send_cyc - dv_cyc, 10);
    check("post_rst_sends", n_send - s0, 15);
    check("post_rst_done",  n_done - d0, 1);
    check("post_rst_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
